alu_classify_pipe: RTL and testbench
====================================

# alu_classify_pipe

Parametrised, pipelined successor to the two-operand ALU with range flags. Accepts operand pairs and an opcode over a valid/ready handshake and computes one of eight operations. It classifies the signed result into Low/Media/High bands with programmable thresholds and flags signed overflow. It also keeps saturating per-band event counters, and sits between the operand source and any result consumer that can apply backpressure.

## Interface
- `WIDTH`, 32, operand/result width (≥ 8)
- `LOW_TH`, -1000000000, signed; Low when Q < LOW_TH
- `MID_TH`, 10000000, positive; Media when -MID_TH < Q < MID_TH
- `HIGH_TH`, 1000000000, signed; High when Q > HIGH_TH
- `CNT_W`, 16, band counter width

Ports:
- `Clk` in 1: single clock, all logic on posedge
- `Reset` in 1: asynchronous, active-high
- `in_valid` in 1: operand beat valid
- `in_ready` out 1: block can accept a beat
- `D0`, `D1` in WIDTH: operands
- `Command` in 3: opcode
- `out_valid` out 1: result beat valid
- `out_ready` in 1: consumer accepts the result
- `Q` out WIDTH: result
- `Low`, `Media`, `High` out 1: band flags for Q
- `Ovf` out 1: signed overflow (ADD/SUB only)
- `clr_cnt` in 1: synchronous clear of all counters
- `low_cnt`, `mid_cnt`, `high_cnt` out CNT_W: handed-off results per band

## Operation
- Opcodes:
  - 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
  - 5 SLT: Q = 1 if $signed(D0) < $signed(D1), else 0.
  - 6 SHL: D0 << D1[$clog2(WIDTH)-1:0].
  - 7 SRA: arithmetic right shift by the same amount.
- Arithmetic wraps modulo 2^WIDTH.
- Ovf is set for ADD/SUB when the operand signs make overflow possible and the result sign differs from the true result. Ovf is 0 for all other opcodes.
- Flags use signed Q with strict compares. Bands may all be 0 (gaps). They are not mutually exclusive if the parameters overlap.
- Pipeline:
  - S1 registers D0/D1/Command on an input handshake (in_valid && in_ready).
  - S2 registers Q, flags and Ovf computed from S1.
  - S2 outputs drive the ports directly.
- Backpressure:
  - s2_adv = !out_valid || out_ready.
  - in_ready = (!s1_valid || s2_adv) && !Reset.
  - S1 moves to S2 when s1_valid && s2_adv.
  - Full throughput of 1 beat/cycle when out_ready is held high.
- Output stability: while out_valid && !out_ready, Q/flags/Ovf are held stable.
- Counters:
  - On an output handoff (out_valid && out_ready), increment each counter whose flag is set.
  - Counters saturate at 2^CNT_W-1.
- clr_cnt: zeroes all counters next edge; clear wins over a simultaneous increment.

## Timing
- Reset (async, immediate): s1_valid = out_valid = 0, Q = 0, Low = High = Ovf = 0, Media = 0, all counters = 0, in_ready = 0.
- Latency: handshake at edge N → out_valid, Q valid after edge N+1 (2 registered stages; observed from the cycle following N+1).
- Handoff at the same edge as a new S1→S2 advance: S2 is replaced without a bubble.
- Reset mid-operation: all in-flight beats are dropped; no counter update.
- Beats are never duplicated or reordered; data is never lost under any out_ready pattern.

## Structure
- Package `alu_classify_pkg`:
  - `typedef enum logic [2:0] alu_op_e` (ADD…SRA).
  - Function `alu_eval` returning {Ovf, Q}.
- Sub-module `alu_band_classifier`: combinational; parameters WIDTH/LOW_TH/MID_TH/HIGH_TH; input Q; outputs Low/Media/High.
- Top holds the pipeline registers, handshake and counters (~200 lines total).

## Test plan
- Reset then single ADD: D0=5, D1=7 → out_valid 2 edges after accept, Q=12, Media=1, Low=High=Ovf=0; mid_cnt=1 after handoff.
- SUB overflow: D0=32'h8000_0000, D1=1 → Q=32'h7FFF_FFFF, Ovf=1, High=1; ADD D0=D1=32'h7FFF_FFFF → Q=32'hFFFF_FFFE, Ovf=1, Media=1.
- Opcode sweep with D0=32'hF0F0_00F0, D1=4:
  - AND → 0; OR → 32'hF0F0_00F4; XOR → 32'hF0F0_00F4.
  - SLT → 1; SHL → 32'h0F00_0F00; SRA → 32'hFF0F_000F.
- Backpressure: stream 10 beats with out_ready toggled 1,0,0,1… → all 10 results in order, Q stable while stalled, in_ready low when both stages are full.
- Counter saturation: CNT_W=2, 5 High results → high_cnt=3; assert clr_cnt with a simultaneous handoff → all counters 0.
- Async reset mid-stream with 2 beats in flight → out_valid drops immediately, no stale output after reset release.

Source files
------------

// File: rtl/alu_classify_pipe_pkg.sv
// Shared opcode type and ALU evaluation for alu_classify_pipe.
// alu_eval works on operands sign-extended to 64 bits, which limits WIDTH to 8..64.
package alu_classify_pkg;

  typedef enum logic [2:0] {
    OP_ADD = 3'd0,
    OP_SUB = 3'd1,
    OP_AND = 3'd2,
    OP_OR  = 3'd3,
    OP_XOR = 3'd4,
    OP_SLT = 3'd5,
    OP_SHL = 3'd6,
    OP_SRA = 3'd7
  } alu_op_e;

  localparam int unsigned EVAL_W = 64;

  // Returns {ovf, result}; only bits [msb:0] of the result are meaningful to the caller.
  function automatic logic [EVAL_W:0] alu_eval(
    input alu_op_e           op,
    input logic [EVAL_W-1:0] a,
    input logic [EVAL_W-1:0] b,
    input logic [5:0]        shamt,
    input logic [5:0]        msb
  );
    logic [EVAL_W-1:0] r;
    logic              ovf;
    r   = '0;
    ovf = 1'b0;
    case (op)
      OP_ADD: begin
        r   = a + b;
        ovf = (a[msb] == b[msb]) && (r[msb] != a[msb]);
      end
      OP_SUB: begin
        r   = a - b;
        ovf = (a[msb] != b[msb]) && (r[msb] != a[msb]);
      end
      OP_AND:  r = a & b;
      OP_OR:   r = a | b;
      OP_XOR:  r = a ^ b;
      OP_SLT:  r = {{(EVAL_W-1){1'b0}}, ($signed(a) < $signed(b))};
      OP_SHL:  r = a << shamt;
      OP_SRA:  r = $signed(a) >>> shamt;
      default: r = '0;
    endcase
    return {ovf, r};
  endfunction

endpackage

// File: rtl/alu_classify_pipe_if.sv
// Operand and result handshake bundle between source, alu_classify_pipe and consumer.
interface alu_classify_pipe_if #(
  parameter int WIDTH = 32
) ();
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] D0;
  logic [WIDTH-1:0] D1;
  logic [2:0]       Command;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] Q;
  logic             Low;
  logic             Media;
  logic             High;
  logic             Ovf;

  modport master (
    output in_valid, D0, D1, Command, out_ready,
    input  in_ready, out_valid, Q, Low, Media, High, Ovf
  );

  modport slave (
    input  in_valid, D0, D1, Command, out_ready,
    output in_ready, out_valid, Q, Low, Media, High, Ovf
  );
endinterface

// File: rtl/alu_classify_pipe_band_classifier.sv
// Combinational Low/Media/High banding of a signed result with strict compares.
module alu_band_classifier #(
  parameter int     WIDTH   = 32,
  parameter longint LOW_TH  = -64'sd1000000000,
  parameter longint MID_TH  = 64'sd10000000,
  parameter longint HIGH_TH = 64'sd1000000000
) (
  input  logic [WIDTH-1:0] Q,
  output logic             Low,
  output logic             Media,
  output logic             High
);
  logic signed [63:0] q_ext_s;

  // Bands may leave gaps or overlap depending on the thresholds chosen.
  always_comb begin
    q_ext_s = 64'(signed'(Q));
    Low     = (q_ext_s < LOW_TH);
    Media   = (q_ext_s > -MID_TH) && (q_ext_s < MID_TH);
    High    = (q_ext_s > HIGH_TH);
  end
endmodule

// File: rtl/alu_classify_pipe.sv
// Two-stage valid/ready ALU with result banding, overflow flag and saturating band counters.
module alu_classify_pipe
  import alu_classify_pkg::*;
#(
  parameter int     WIDTH   = 32,
  parameter longint LOW_TH  = -64'sd1000000000,
  parameter longint MID_TH  = 64'sd10000000,
  parameter longint HIGH_TH = 64'sd1000000000,
  parameter int     CNT_W   = 16
) (
  input  logic                 Clk,
  input  logic                 Reset,
  alu_classify_pipe_if.slave   bus,
  input  logic                 clr_cnt,
  output logic [CNT_W-1:0]     low_cnt,
  output logic [CNT_W-1:0]     mid_cnt,
  output logic [CNT_W-1:0]     high_cnt
);
  localparam int               SH_W    = $clog2(WIDTH);
  localparam logic [5:0]       MSB     = 6'(WIDTH - 1);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] s1_d0_q, s1_d0_d, s1_d1_q, s1_d1_d;
  alu_op_e          s1_op_q, s1_op_d;

  logic             out_valid_q, out_valid_d;
  logic [WIDTH-1:0] q_q, q_d;
  logic             low_q, low_d, media_q, media_d, high_q, high_d, ovf_q, ovf_d;

  logic [CNT_W-1:0] low_cnt_q, low_cnt_d, mid_cnt_q, mid_cnt_d, high_cnt_q, high_cnt_d;

  logic             s2_adv_s, in_fire_s, s1_adv_s, handoff_s;
  logic [EVAL_W:0]  eval_s;
  logic [WIDTH-1:0] alu_q_s;
  logic             alu_ovf_s, band_low_s, band_media_s, band_high_s;
  logic             unused_s;

  function automatic logic [CNT_W-1:0] cnt_next(
    input logic [CNT_W-1:0] cnt,
    input logic             inc,
    input logic             clr
  );
    logic [CNT_W-1:0] n;
    if (clr) begin
      n = '0;
    end else if (inc && (cnt != CNT_MAX)) begin
      n = cnt + CNT_W'(1);
    end else begin
      n = cnt;
    end
    return n;
  endfunction

  assign s2_adv_s     = !out_valid_q || bus.out_ready;
  assign bus.in_ready = (!s1_valid_q || s2_adv_s) && !Reset;
  assign in_fire_s    = bus.in_valid && bus.in_ready;
  assign s1_adv_s     = s1_valid_q && s2_adv_s;
  assign handoff_s    = out_valid_q && bus.out_ready;

  assign eval_s    = alu_eval(s1_op_q, 64'(signed'(s1_d0_q)), 64'(signed'(s1_d1_q)),
                              6'(s1_d1_q[SH_W-1:0]), MSB);
  assign alu_q_s   = eval_s[WIDTH-1:0];
  assign alu_ovf_s = eval_s[EVAL_W];
  assign unused_s  = &{1'b0, eval_s[EVAL_W-1:WIDTH-1]};

  alu_band_classifier #(
    .WIDTH  (WIDTH),
    .LOW_TH (LOW_TH),
    .MID_TH (MID_TH),
    .HIGH_TH(HIGH_TH)
  ) u_band (
    .Q    (alu_q_s),
    .Low  (band_low_s),
    .Media(band_media_s),
    .High (band_high_s)
  );

  // S1 capture; a new beat may load in the same cycle the old one advances.
  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_d0_d    = s1_d0_q;
    s1_d1_d    = s1_d1_q;
    s1_op_d    = s1_op_q;
    if (in_fire_s) begin
      s1_valid_d = 1'b1;
      s1_d0_d    = bus.D0;
      s1_d1_d    = bus.D1;
      s1_op_d    = alu_op_e'(bus.Command);
    end else if (s1_adv_s) begin
      s1_valid_d = 1'b0;
    end else begin
      s1_valid_d = s1_valid_q;
    end
  end

  // S2 result; held while the consumer stalls.
  always_comb begin
    out_valid_d = out_valid_q;
    q_d         = q_q;
    low_d       = low_q;
    media_d     = media_q;
    high_d      = high_q;
    ovf_d       = ovf_q;
    if (s1_adv_s) begin
      out_valid_d = 1'b1;
      q_d         = alu_q_s;
      low_d       = band_low_s;
      media_d     = band_media_s;
      high_d      = band_high_s;
      ovf_d       = alu_ovf_s;
    end else if (handoff_s) begin
      out_valid_d = 1'b0;
    end else begin
      out_valid_d = out_valid_q;
    end
  end

  // Band counters count handed-off results only.
  always_comb begin
    low_cnt_d  = cnt_next(low_cnt_q,  handoff_s && low_q,   clr_cnt);
    mid_cnt_d  = cnt_next(mid_cnt_q,  handoff_s && media_q, clr_cnt);
    high_cnt_d = cnt_next(high_cnt_q, handoff_s && high_q,  clr_cnt);
  end

  // State registers for both stages and the counters.
  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      s1_valid_q  <= 1'b0;
      s1_d0_q     <= '0;
      s1_d1_q     <= '0;
      s1_op_q     <= OP_ADD;
      out_valid_q <= 1'b0;
      q_q         <= '0;
      low_q       <= 1'b0;
      media_q     <= 1'b0;
      high_q      <= 1'b0;
      ovf_q       <= 1'b0;
      low_cnt_q   <= '0;
      mid_cnt_q   <= '0;
      high_cnt_q  <= '0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_d0_q     <= s1_d0_d;
      s1_d1_q     <= s1_d1_d;
      s1_op_q     <= s1_op_d;
      out_valid_q <= out_valid_d;
      q_q         <= q_d;
      low_q       <= low_d;
      media_q     <= media_d;
      high_q      <= high_d;
      ovf_q       <= ovf_d;
      low_cnt_q   <= low_cnt_d;
      mid_cnt_q   <= mid_cnt_d;
      high_cnt_q  <= high_cnt_d;
    end
  end

  assign bus.out_valid = out_valid_q;
  assign bus.Q         = q_q;
  assign bus.Low       = low_q;
  assign bus.Media     = media_q;
  assign bus.High      = high_q;
  assign bus.Ovf       = ovf_q;
  assign low_cnt       = low_cnt_q;
  assign mid_cnt       = mid_cnt_q;
  assign high_cnt      = high_cnt_q;
endmodule

// File: tb/tb_alu_classify_pipe.sv
// Scoreboard bench for alu_classify_pipe: expectations queued on accept, checked on output.
module tb_alu_classify_pipe;
  localparam int W  = 32;
  localparam int CW = 2;

  logic          Clk = 1'b0;
  logic          Reset;
  logic          clr_cnt;
  logic [CW-1:0] low_cnt, mid_cnt, high_cnt;

  alu_classify_pipe_if #(.WIDTH(W)) bus ();

  alu_classify_pipe #(.WIDTH(W), .CNT_W(CW)) dut (
    .Clk     (Clk),
    .Reset   (Reset),
    .bus     (bus),
    .clr_cnt (clr_cnt),
    .low_cnt (low_cnt),
    .mid_cnt (mid_cnt),
    .high_cnt(high_cnt)
  );

  always #5 Clk = ~Clk;

  // flags = {Low, Media, High, Ovf}; acc = clock edge at which the beat was accepted
  typedef struct packed {
    logic [31:0] q;
    logic [3:0]  flags;
    int          acc;
  } exp_t;

  typedef struct packed {
    logic [2:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;
  } dir_t;

  exp_t          exp_q[$];
  exp_t          cur_exp;
  dir_t          dirs[$];
  int            n_checks = 0;
  int            n_errors = 0;
  int            cyc = 0;
  int            saw_full = 0;
  int            rdy_mode = 0;
  logic          accepted_s;
  logic          stalled_prev = 1'b0;
  logic [31:0]   held_q = 32'd0;
  logic [CW-1:0] cm_low = '0, cm_mid = '0, cm_high = '0;
  logic          bp_pat [4] = '{1'b1, 1'b0, 1'b0, 1'b1};

  task automatic check_val(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, act, exp);
    end
  endtask

  function automatic exp_t model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    exp_t               e;
    logic [31:0]        r;
    logic signed [32:0] t;
    logic               ov;
    int                 s;
    ov = 1'b0;
    t  = 33'sd0;
    case (op)
      3'd0: begin t = $signed({a[31], a}) + $signed({b[31], b}); r = t[31:0]; ov = (t[32] != t[31]); end
      3'd1: begin t = $signed({a[31], a}) - $signed({b[31], b}); r = t[31:0]; ov = (t[32] != t[31]); end
      3'd2: r = a & b;
      3'd3: r = a | b;
      3'd4: r = a ^ b;
      3'd5: r = ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
      3'd6: r = a << b[4:0];
      3'd7: r = $signed(a) >>> b[4:0];
      default: r = 32'd0;
    endcase
    s       = $signed(r);
    e.q     = r;
    e.flags = {s < -1000000000, (s > -10000000) && (s < 10000000), s > 1000000000, ov};
    e.acc   = 0;
    return e;
  endfunction

  task automatic step();
    exp_t f;
    logic exp_ov;
    bus.out_ready = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? bp_pat[cyc % 4] : 1'b0;
    @(negedge Clk);
    exp_ov = 1'b0;
    if (exp_q.size() > 0) exp_ov = (exp_q[0].acc < cyc);
    check_val("out_valid", bus.out_valid, exp_ov);
    check_val("in_ready", bus.in_ready, (exp_q.size() < 2) || bus.out_ready);
    check_val("counters", {low_cnt, mid_cnt, high_cnt}, {cm_low, cm_mid, cm_high});
    if (exp_ov && bus.out_valid) begin
      if (stalled_prev) check_val("q_stable", bus.Q, held_q);
      check_val("q", bus.Q, exp_q[0].q);
      check_val("flags", {bus.Low, bus.Media, bus.High, bus.Ovf}, exp_q[0].flags);
    end
    if (bus.in_valid && !bus.in_ready) saw_full++;
    stalled_prev = bus.out_valid && !bus.out_ready;
    held_q       = bus.Q;
    if (bus.out_valid && bus.out_ready && exp_q.size() > 0) begin
      f = exp_q.pop_front();
      if (f.flags[3] && cm_low  != 2'b11) cm_low++;
      if (f.flags[2] && cm_mid  != 2'b11) cm_mid++;
      if (f.flags[1] && cm_high != 2'b11) cm_high++;
    end
    if (clr_cnt) begin
      cm_low = '0; cm_mid = '0; cm_high = '0;
    end
    if (bus.in_valid && bus.in_ready) begin
      cur_exp.acc = cyc + 1;
      exp_q.push_back(cur_exp);
      accepted_s = 1'b1;
    end
    @(posedge Clk);
    #1;
    cyc++;
  endtask

  task automatic send(input logic [2:0] op, input logic [31:0] d0, input logic [31:0] d1, input exp_t e);
    bus.in_valid = 1'b1;
    bus.Command  = op;
    bus.D0       = d0;
    bus.D1       = d1;
    cur_exp      = e;
    accepted_s   = 1'b0;
    for (int i = 0; i < 50 && !accepted_s; i++) step();
    check_val("accepted", accepted_s, 1'b1);
  endtask

  task automatic send_rand();
    logic [2:0]  op;
    logic [31:0] a, b;
    op = 3'($urandom_range(0, 7));
    a  = $urandom;
    b  = $urandom;
    send(op, a, b, model(op, a, b));
  endtask

  task automatic drain();
    bus.in_valid = 1'b0;
    for (int i = 0; i < 100 && exp_q.size() > 0; i++) step();
    check_val("drained", exp_q.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int c0;
    Reset         = 1'b1;
    clr_cnt       = 1'b0;
    bus.in_valid  = 1'b0;
    bus.D0        = 32'd0;
    bus.D1        = 32'd0;
    bus.Command   = 3'd0;
    bus.out_ready = 1'b1;
    #12;
    check_val("rst_out_valid", bus.out_valid, 1'b0);
    check_val("rst_in_ready", bus.in_ready, 1'b0);
    check_val("rst_q", bus.Q, 32'd0);
    check_val("rst_flags", {bus.Low, bus.Media, bus.High, bus.Ovf}, 4'b0000);
    check_val("rst_cnt", {low_cnt, mid_cnt, high_cnt}, 6'd0);
    @(posedge Clk);
    #1;
    Reset = 1'b0;

    // single ADD with explicit expectations
    send(3'd0, 32'd5, 32'd7, '{q: 32'd12, flags: 4'b0100, acc: 0});
    drain();
    check_val("mid_cnt_first", mid_cnt, 2'd1);

    dirs.push_back('{op: 3'd1, a: 32'h8000_0000, b: 32'd1,         q: 32'h7FFF_FFFF, f: 4'b0011});
    dirs.push_back('{op: 3'd0, a: 32'h7FFF_FFFF, b: 32'h7FFF_FFFF, q: 32'hFFFF_FFFE, f: 4'b0101});
    dirs.push_back('{op: 3'd0, a: 32'hC000_0000, b: 32'd0,         q: 32'hC000_0000, f: 4'b1000});
    dirs.push_back('{op: 3'd2, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'h0000_0000, f: 4'b0100});
    dirs.push_back('{op: 3'd3, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'hF0F0_00F4, f: 4'b0000});
    dirs.push_back('{op: 3'd4, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'hF0F0_00F4, f: 4'b0000});
    dirs.push_back('{op: 3'd5, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'h0000_0001, f: 4'b0100});
    dirs.push_back('{op: 3'd6, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'h0F00_0F00, f: 4'b0000});
    dirs.push_back('{op: 3'd7, a: 32'hF0F0_00F0, b: 32'd4,         q: 32'hFF0F_000F, f: 4'b0000});
    dirs.push_back('{op: 3'd0, a: 32'h3B9A_CA00, b: 32'd0,         q: 32'h3B9A_CA00, f: 4'b0000});
    dirs.push_back('{op: 3'd0, a: 32'h3B9A_CA01, b: 32'd0,         q: 32'h3B9A_CA01, f: 4'b0010});
    dirs.push_back('{op: 3'd0, a: 32'h0098_967F, b: 32'd0,         q: 32'h0098_967F, f: 4'b0100});
    dirs.push_back('{op: 3'd0, a: 32'hFF67_6980, b: 32'd0,         q: 32'hFF67_6980, f: 4'b0000});
    dirs.push_back('{op: 3'd0, a: 32'hC465_3600, b: 32'd0,         q: 32'hC465_3600, f: 4'b0000});
    dirs.push_back('{op: 3'd0, a: 32'hC465_35FF, b: 32'd0,         q: 32'hC465_35FF, f: 4'b1000});
    dirs.push_back('{op: 3'd1, a: 32'h7FFF_FFFF, b: 32'hFFFF_FFFF, q: 32'h8000_0000, f: 4'b1001});
    foreach (dirs[i]) send(dirs[i].op, dirs[i].a, dirs[i].b, '{q: dirs[i].q, flags: dirs[i].f, acc: 0});
    drain();

    // saturation at CNT_W=2, then clear racing a handoff
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    for (int i = 0; i < 5; i++) send(3'd0, 32'h3B9A_CA01, 32'd0, '{q: 32'h3B9A_CA01, flags: 4'b0010, acc: 0});
    drain();
    check_val("high_sat", high_cnt, 2'd3);
    send(3'd0, 32'd1, 32'd2, '{q: 32'd3, flags: 4'b0100, acc: 0});
    bus.in_valid = 1'b0;
    step();
    clr_cnt = 1'b1;
    step();
    clr_cnt = 1'b0;
    check_val("clr_handoff_pop", exp_q.size(), 0);
    check_val("clr_wins", {low_cnt, mid_cnt, high_cnt}, 6'd0);

    // full throughput with out_ready held high
    c0 = cyc;
    for (int i = 0; i < 8; i++) send_rand();
    check_val("throughput", cyc - c0, 8);
    drain();

    // backpressure 1,0,0,1 pattern
    rdy_mode = 1;
    saw_full = 0;
    for (int i = 0; i < 10; i++) send_rand();
    drain();
    check_val("saw_full", saw_full > 0, 1'b1);

    // async reset with two beats in flight
    rdy_mode = 2;
    send(3'd0, 32'd10, 32'd20, '{q: 32'd30, flags: 4'b0100, acc: 0});
    send(3'd0, 32'd11, 32'd20, '{q: 32'd31, flags: 4'b0100, acc: 0});
    bus.in_valid = 1'b0;
    check_val("two_in_flight", exp_q.size(), 2);
    #2;
    Reset = 1'b1;
    #1;
    check_val("arst_out_valid", bus.out_valid, 1'b0);
    check_val("arst_in_ready", bus.in_ready, 1'b0);
    check_val("arst_q", bus.Q, 32'd0);
    exp_q.delete();
    cm_low = '0; cm_mid = '0; cm_high = '0;
    stalled_prev = 1'b0;
    @(posedge Clk);
    #1;
    cyc++;
    Reset    = 1'b0;
    rdy_mode = 0;
    for (int i = 0; i < 5; i++) step();
    send(3'd4, 32'hFFFF_0000, 32'h00FF_FF00, model(3'd4, 32'hFFFF_0000, 32'h00FF_FF00));
    drain();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
